// File: rtl/msk_rx_deframer.sv
// MSK receive deframer: hunts for SYNC_WORD in the demodulated bit stream, then packs
// FRAME_BYTES payload bytes onto a byte stream. Define MSK_DEFRAMER_INV_EN to also lock on ~SYNC_WORD.
module msk_rx_deframer #(
    parameter logic [31:0] SYNC_WORD   = 32'h1ACF_FC1D,
    parameter int          MAX_ERR     = 0,
    parameter int          FRAME_BYTES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        locked,
    output logic        inverted,
    output logic        overflow,
    output logic [15:0] frame_cnt
);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [5:0] MAX_ERR_W = 6'(MAX_ERR);
    localparam logic [7:0] LAST_IDX  = 8'(FRAME_BYTES - 1);

    state_t      state_q, state_d;
    // Only the 31 most recent bits are stored; the incoming bit completes the 32-bit window.
    logic [30:0] sync_q, sync_d;
    logic [31:0] sync_shift;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [6:0]  byte_q, byte_d;
    logic [7:0]  new_byte;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        ovf_q, ovf_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        match_true;
    logic        match_inv;
    logic        inv_q;
    logic        payload_bit;

    function automatic logic [5:0] hamming(input logic [31:0] a, input logic [31:0] b);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, a[i] ^ b[i]};
        end
        return n;
    endfunction

    assign sync_shift = {sync_q, bit_in};
    assign match_true = (hamming(sync_shift, SYNC_WORD) <= MAX_ERR_W);

`ifdef MSK_DEFRAMER_INV_EN
    assign match_inv   = (hamming(sync_shift, ~SYNC_WORD) <= MAX_ERR_W);
    assign payload_bit = bit_in ^ inv_q;

    // Polarity is decided at lock time and held until the next lock; a true match wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            inv_q <= 1'b0;
        end else if (bit_valid && (state_q == HUNT) && (match_true || match_inv)) begin
            inv_q <= !match_true;
        end
    end
`else
    assign match_inv   = 1'b0;
    assign payload_bit = bit_in;
    assign inv_q       = 1'b0;
`endif

    assign new_byte = {byte_q, payload_bit};

    // Output handshake: a byte transfers on any rising edge where m_tvalid && m_tready;
    // m_tdata/m_tlast are stable while m_tvalid is high and not yet accepted.
    always_comb begin
        state_d    = state_q;
        sync_d     = sync_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        byte_d     = byte_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        ovf_d      = 1'b0;
        fcnt_d     = fcnt_q;

        if (tvalid_q && m_tready) begin
            tvalid_d = 1'b0;
        end

        if (bit_valid) begin
            sync_d = sync_shift[30:0];
            case (state_q)
                HUNT: begin
                    if (match_true || match_inv) begin
                        state_d    = COLLECT;
                        fcnt_d     = fcnt_q + 16'd1;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        byte_d     = '0;
                    end
                end
                COLLECT: begin
                    byte_d    = new_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        if (tvalid_q && !m_tready) begin
                            ovf_d = 1'b1;
                        end else begin
                            tdata_d  = new_byte;
                            tvalid_d = 1'b1;
                            tlast_d  = (byte_cnt_q == LAST_IDX);
                        end
                        if (byte_cnt_q == LAST_IDX) begin
                            state_d    = HUNT;
                            sync_d     = '0;
                            byte_cnt_d = '0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HUNT;
            sync_q     <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            byte_q     <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            ovf_q      <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            byte_q     <= byte_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            ovf_q      <= ovf_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign m_tdata   = tdata_q;
    assign m_tvalid  = tvalid_q;
    assign m_tlast   = tlast_q;
    assign locked    = (state_q == COLLECT);
    assign inverted  = inv_q;
    assign overflow  = ovf_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_msk_rx_deframer.sv
// Bench for msk_rx_deframer: two instances (MAX_ERR 0 and 1) on shared inputs, each checked
// every cycle against a bit-stream reference model, plus directed scenario checks.
module tb_msk_rx_deframer;

    localparam logic [31:0] SW = 32'h1ACF_FC1D;
    localparam int          FB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        m_tready = 1'b1;

    logic [7:0]  d0_tdata, d1_tdata;
    logic        d0_tvalid, d1_tvalid, d0_tlast, d1_tlast;
    logic        d0_locked, d1_locked, d0_inv, d1_inv, d0_ovf, d1_ovf;
    logic [15:0] d0_fcnt, d1_fcnt;

    always #5 clk = ~clk;

    msk_rx_deframer #(.SYNC_WORD(SW), .MAX_ERR(0), .FRAME_BYTES(FB)) dut0 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .m_tdata(d0_tdata), .m_tvalid(d0_tvalid), .m_tready(m_tready), .m_tlast(d0_tlast),
        .locked(d0_locked), .inverted(d0_inv), .overflow(d0_ovf), .frame_cnt(d0_fcnt)
    );

    msk_rx_deframer #(.SYNC_WORD(SW), .MAX_ERR(1), .FRAME_BYTES(FB)) dut1 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .m_tdata(d1_tdata), .m_tvalid(d1_tvalid), .m_tready(m_tready), .m_tlast(d1_tlast),
        .locked(d1_locked), .inverted(d1_inv), .overflow(d1_ovf), .frame_cnt(d1_fcnt)
    );

    int total = 0;
    int bad = 0;
    int ovf_seen = 0;
    int ready_mode = 0;
    int gap_cfg = 20;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Reference model, one slot per instance: sliding 32-bit history, lock flag, bit accumulator.
    logic [31:0] h_m[2];
    bit          lock_m[2];
    bit          inv_m[2];
    int          acc_m[2];
    int          nb_m[2];
    int          nbyt_m[2];
    logic [7:0]  ed_m[2];
    bit          ev_m[2];
    bit          el_m[2];
    bit          eo_m[2];
    logic [15:0] ef_m[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int k, input int me);
        bit old_valid;
        eo_m[k] = 1'b0;
        if (reset) begin
            h_m[k] = '0; lock_m[k] = 0; inv_m[k] = 0; acc_m[k] = 0; nb_m[k] = 0; nbyt_m[k] = 0;
            ed_m[k] = '0; ev_m[k] = 0; el_m[k] = 0; ef_m[k] = '0;
            return;
        end
        old_valid = ev_m[k];
        if (old_valid && m_tready) ev_m[k] = 0;
        if (bit_valid) begin
            h_m[k] = {h_m[k][30:0], bit_in};
            if (!lock_m[k]) begin
                if ($countones(h_m[k] ^ SW) <= me) begin
                    lock_m[k] = 1; inv_m[k] = 0; ef_m[k] = ef_m[k] + 16'd1;
                    acc_m[k] = 0; nb_m[k] = 0; nbyt_m[k] = 0;
                end
`ifdef MSK_DEFRAMER_INV_EN
                else if ($countones(h_m[k] ^ ~SW) <= me) begin
                    lock_m[k] = 1; inv_m[k] = 1; ef_m[k] = ef_m[k] + 16'd1;
                    acc_m[k] = 0; nb_m[k] = 0; nbyt_m[k] = 0;
                end
`endif
            end else begin
                acc_m[k] = acc_m[k] * 2 + ((bit_in ^ inv_m[k]) ? 1 : 0);
                nb_m[k]++;
                if (nb_m[k] == 8) begin
                    nbyt_m[k]++;
                    if (old_valid && !m_tready) begin
                        eo_m[k] = 1;
                    end else begin
                        ed_m[k] = 8'(acc_m[k]);
                        ev_m[k] = 1;
                        el_m[k] = (nbyt_m[k] == FB);
                    end
                    acc_m[k] = 0;
                    nb_m[k] = 0;
                    if (nbyt_m[k] == FB) begin
                        lock_m[k] = 0;
                        h_m[k] = '0;
                    end
                end
            end
        end
    endtask

    task automatic check_dut(input int k, input logic [7:0] td, input logic tv, input logic tl,
                             input logic lk, input logic iv, input logic ov, input logic [15:0] fc);
        chk($sformatf("d%0d.tdata", k), td, ed_m[k]);
        chk($sformatf("d%0d.tvalid", k), tv, ev_m[k]);
        chk($sformatf("d%0d.tlast", k), tl, el_m[k]);
        chk($sformatf("d%0d.locked", k), lk, lock_m[k]);
        chk($sformatf("d%0d.inverted", k), iv, inv_m[k]);
        chk($sformatf("d%0d.overflow", k), ov, eo_m[k]);
        chk($sformatf("d%0d.frame_cnt", k), fc, ef_m[k]);
    endtask

    // One clock: drive inputs at the falling edge, model at the rising edge, check at the next fall.
    task automatic cycle(input bit bv, input bit b);
        bit_valid = bv;
        bit_in = b;
        case (ready_mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
        if (d0_tvalid && m_tready) got_q.push_back(d0_tdata);
        @(posedge clk);
        model_step(0, 0);
        model_step(1, 1);
        @(negedge clk);
        check_dut(0, d0_tdata, d0_tvalid, d0_tlast, d0_locked, d0_inv, d0_ovf, d0_fcnt);
        check_dut(1, d1_tdata, d1_tvalid, d1_tlast, d1_locked, d1_inv, d1_ovf, d1_fcnt);
        if (d0_ovf) ovf_seen++;
    endtask

    task automatic send_bit(input bit b);
        int g;
        g = (gap_cfg > 0) ? gap_cfg : int'($urandom_range(2, 5));
        cycle(1'b1, b);
        repeat (g - 1) cycle(1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_byte_rec(input logic [7:0] v);
        exp_q.push_back(v);
        send_byte(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) cycle(1'b0, 1'b0);
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        ovf_seen = 0;
    endtask

    task automatic sb_check(input string tag);
        int n;
        chk({tag, ".count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s.byte%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic rand_frame();
        logic [31:0] w;
        int n;
        n = $urandom_range(0, 40);
        repeat (n) send_bit(1'($urandom_range(0, 1)));
        w = SW;
        if ($urandom_range(0, 1) == 1) w[$urandom_range(0, 31)] = ~w[$urandom_range(0, 31)];
        send_word(w);
        repeat (FB) send_byte(8'($urandom));
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("reset.tdata", d0_tdata, 8'h00);
        chk("reset.tvalid", d0_tvalid, 1'b0);
        chk("reset.locked", d0_locked, 1'b0);
        chk("reset.frame_cnt", d0_fcnt, 16'h0000);

        // Nominal frame, bit strobe every 20 clocks
        gap_cfg = 20;
        ready_mode = 0;
        send_word(SW);
        chk("nominal.locked_after_sync", d0_locked, 1'b1);
        for (int i = 0; i < FB; i++) send_byte_rec(8'(i));
        cycle(1'b0, 1'b0);
        sb_check("nominal");
        chk("nominal.frame_cnt", d0_fcnt, 16'd1);
        chk("nominal.unlocked", d0_locked, 1'b0);

        // Single bit error in sync: only the MAX_ERR=1 instance locks
        do_reset();
        gap_cfg = 3;
        send_word(SW ^ 32'h0000_0020);
        chk("biterr.d0_locked", d0_locked, 1'b0);
        chk("biterr.d1_locked", d1_locked, 1'b1);
        chk("biterr.d1_frame_cnt", d1_fcnt, 16'd1);
        repeat (FB) send_byte(8'($urandom));

        // Backpressure: second completed byte dropped while the first is held
        do_reset();
        ready_mode = 2;
        send_word(SW);
        send_byte(8'hA7);
        send_byte(8'h3C);
        chk("bp.held_data", d0_tdata, 8'hA7);
        chk("bp.held_valid", d0_tvalid, 1'b1);
        chk("bp.overflow_pulses", ovf_seen, 1);
        ready_mode = 0;
        got_q.delete();
        cycle(1'b0, 1'b0);
        chk("bp.delivered_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("bp.delivered_byte", got_q[0], 8'hA7);
        repeat (FB - 2) send_byte(8'($urandom));

        // Reset in the middle of a frame, then a fresh frame
        do_reset();
        gap_cfg = 0;
        send_word(SW);
        repeat (3) send_byte(8'($urandom));
        reset = 1'b1;
        cycle(1'b0, 1'b0);
        reset = 1'b0;
        chk("midrst.tdata", d0_tdata, 8'h00);
        chk("midrst.tvalid", d0_tvalid, 1'b0);
        chk("midrst.locked", d0_locked, 1'b0);
        chk("midrst.frame_cnt", d0_fcnt, 16'h0000);
        got_q.delete();
        exp_q.delete();
        send_word(SW);
        repeat (FB) send_byte_rec(8'($urandom));
        repeat (3) cycle(1'b0, 1'b0);
        sb_check("midrst");
        chk("midrst.frame_cnt_after", d0_fcnt, 16'd1);

        // Inverted sync word
        do_reset();
        gap_cfg = 3;
        send_word(~SW);
        send_byte(8'hA5);
`ifdef MSK_DEFRAMER_INV_EN
        chk("inv.inverted", d0_inv, 1'b1);
        chk("inv.tdata", d0_tdata, 8'h5A);
        chk("inv.tvalid", d0_tvalid, 1'b1);
`else
        chk("inv.no_lock", d0_locked, 1'b0);
        chk("inv.frame_cnt", d0_fcnt, 16'h0000);
`endif

        // Back-to-back frames whose payload embeds the sync word, minimum strobe spacing
        do_reset();
        gap_cfg = 2;
        for (int f = 0; f < 2; f++) begin
            send_word(SW);
            send_byte_rec(8'h1A); send_byte_rec(8'hCF); send_byte_rec(8'hFC); send_byte_rec(8'h1D);
            for (int i = 4; i < FB; i++) send_byte_rec(8'(i + 16 * f));
        end
        repeat (3) cycle(1'b0, 1'b0);
        sb_check("b2b");
        chk("b2b.frame_cnt", d0_fcnt, 16'd2);

        // Randomized frames with noise, sync bit errors, random gaps and random ready
        do_reset();
        gap_cfg = 0;
        ready_mode = 1;
        repeat (6) rand_frame();
        ready_mode = 0;
        repeat (5) cycle(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
